// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit.
// Shift-add multiply over a 2*WIDTH accumulator, restoring division on magnitudes,
// with sign correction applied in a single FIX cycle. Divide-by-zero and signed
// overflow bypass the iteration and complete after one edge.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [W2-1:0]    r_acc;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_opnd;
    logic [CW-1:0]    r_count;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_sc_result;
    logic [WIDTH:0]   w_sum;
    logic [W2-1:0]    w_mul_next;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [W2-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_remf;
    logic [WIDTH-1:0] w_fix_result;

    // {zero, sign, dz, overflow} derived from a final result
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res,
                                            input logic dz, input logic ov);
        return {(res == '0), res[WIDTH-1], dz, ov};
    endfunction

    // Operand decode at start: signedness, magnitudes and the bypass cases
    always_comb begin
        w_a_signed  = 1'b0;
        w_b_signed  = 1'b0;
        case (op)
            OP_MULH:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OP_MULHSU: begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            OP_DIV,
            OP_REM:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default:   begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
        w_sa        = w_a_signed & a[WIDTH-1];
        w_sb        = w_b_signed & b[WIDTH-1];
        w_abs_a     = w_sa ? (~a + WIDTH'(1)) : a;
        w_abs_b     = w_sb ? (~b + WIDTH'(1)) : b;
        w_div_zero  = op[2] && (b == '0);
        w_div_ovf   = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
        w_sc_result = '0;
        if (w_div_zero) begin
            w_sc_result = op[1] ? a : '1;
        end else if (w_div_ovf) begin
            w_sc_result = op[1] ? '0 : a;
        end
    end

    // One multiply or restoring-divide step from the current accumulator
    always_comb begin
        w_sum      = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_opnd};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[W2-1:1]};
        w_shift    = {r_rem, r_acc[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_opnd});
        w_diff     = WIDTH'(w_shift - {1'b0, r_opnd});
    end

    // Sign correction and half/quotient/remainder selection for the FIX cycle
    always_comb begin
        w_prod       = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
        w_quo        = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
        w_remf       = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
        w_fix_result = '0;
        case (r_op)
            OP_MUL:    w_fix_result = w_prod[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_fix_result = w_prod[W2-1:WIDTH];
            OP_DIV,
            OP_DIVU:   w_fix_result = w_quo;
            OP_REM,
            OP_REMU:   w_fix_result = w_remf;
            default:   w_fix_result = '0;
        endcase
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_opnd   <= '0;
            r_count  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE,
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        r_op    <= op;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_sc_result;
                            r_flags  <= mk_flags(w_sc_result, w_div_zero, w_div_ovf);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_count <= CW'(WIDTH);
                            r_rem   <= '0;
                            if (op[2]) begin
                                r_opnd <= w_abs_b;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            end else begin
                                r_opnd <= w_abs_a;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            end
                        end
                    end
                end
                S_CALC: begin
                    r_count <= r_count - CW'(1);
                    if (r_op[2]) begin
                        r_acc <= {r_acc[W2-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    if (r_count == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_flags  <= mk_flags(w_fix_result, 1'b0, 1'b0);
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start from a negedge; scramble operands afterwards
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = ~y;
    endtask

    // Edges from the start edge (inclusive) up to the edge that raised done
    task automatic wait_done(output int edges);
        edges = 1;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input logic [3:0] exp_flags, input int exp_lat, input bit b2b);
        int lat;
        if (!b2b) @(negedge clk);
        issue(o, x, y);
        check({tag, " busy"}, 32'(busy), 32'(exp_lat > 1));
        wait_done(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, 32'(flags), 32'(exp_flags));
    endtask

    initial begin
        int nd;
        logic [31:0] got;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        reset = 1'b0;

        // Multiply class
        run("MUL 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 4'b0100, 34, 1'b0);
        @(negedge clk);
        check("done pulse width", 32'(done), 32'd0);
        run("MULH min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000, 34, 1'b0);
        run("MULHU max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, 34, 1'b0);
        run("MULHSU -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 34, 1'b0);
        run("MUL min*2", MUL, 32'h8000_0000, 32'd2, 32'd0, 4'b1000, 34, 1'b0);
        run("MULHU min*2", MULHU, 32'h8000_0000, 32'd2, 32'd1, 4'b0000, 34, 1'b0);

        // Divide class
        run("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b0100, 34, 1'b0);
        run("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b0100, 34, 1'b0);
        run("DIVU big/2", DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 4'b0000, 34, 1'b0);
        run("REMU 9/3", REMU, 32'd9, 32'd3, 32'd0, 4'b1000, 34, 1'b0);
        run("DIV 100/-7", DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 4'b0100, 34, 1'b0);
        run("REM 100/-7", REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 4'b0000, 34, 1'b0);
        run("DIV min/1", DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 4'b0100, 34, 1'b0);
        run("REMU max/16", REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 4'b0000, 34, 1'b0);
        run("DIV 0/5", DIV, 32'd0, 32'd5, 32'd0, 4'b1000, 34, 1'b0);

        // Bypass cases
        run("DIVU 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b0110, 1, 1'b0);
        run("REMU 5/0", REMU, 32'd5, 32'd0, 32'd5, 4'b0010, 1, 1'b0);
        run("DIV 7/0", DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'b0110, 1, 1'b0);
        run("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0101, 1, 1'b0);
        run("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'b1001, 1, 1'b0);

        // Start while busy is ignored
        @(negedge clk);
        issue(MUL, 32'd6, 32'd7);
        repeat (6) @(negedge clk);
        start = 1'b1;
        op    = MUL;
        a     = 32'd3;
        b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nd  = 0;
        got = '0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                got = result;
            end
        end
        check("busy start done count", nd, 1);
        check("busy start result", got, 32'd42);

        // Back-to-back start in the DONE cycle
        run("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14, 4'b0000, 34, 1'b0);
        run("REMU 100/7 b2b", REMU, 32'd100, 32'd7, 32'd2, 4'b0000, 34, 1'b1);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        issue(MUL, 32'h1234, 32'h10);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset result", result, 32'd0);
        check("mid reset flags", 32'(flags), 32'd0);
        repeat (3) @(negedge clk);
        check("held reset done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("no stale done", 32'(done), 32'd0);
        check("no stale result", result, 32'd0);
        run("MUL 6*7 after reset", MUL, 32'd6, 32'd7, 32'd42, 4'b0000, 34, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
